// File: rtl/adc_trace_reader.sv
// adc_trace_reader: copies one triggered capture-buffer record into trace memory during vblank.
// Optional per-record min/max tracking is compiled in with `define TRACE_PEAK_DETECT_EN.
module adc_trace_reader #(
  parameter int N_SAMPLES = 640,
  parameter int PRE_TRIG  = 320
) (
  input  logic        CLK_64MHZ,
  input  logic        MASTER_RST_N,
  input  logic        BUF_READY,
  input  logic [10:0] TRIG_ADDR,
  input  logic        VBLANK,
  output logic [10:0] RAM_ADDR,
  input  logic [7:0]  RAM_DATA,
  output logic [9:0]  TRACE_ADDR,
  output logic [7:0]  TRACE_DATA,
  output logic        TRACE_WE,
  output logic        VGA_WRITE_DONE,
  output logic [7:0]  TRACE_MIN,
  output logic [7:0]  TRACE_MAX,
  output logic [2:0]  STATE_DBG
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VB = 3'd1,
    READ    = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [10:0] PRE_TRIG_W = 11'(PRE_TRIG);
  localparam logic [9:0]  LAST_IDX   = 10'(N_SAMPLES - 1);

  state_t      state;
  logic [10:0] start_addr;
  logic [9:0]  rd_idx;
  logic [9:0]  pipe_idx;
  logic        pipe_vld;
  logic        flush_cnt;
  logic        read_entry;
  logic        done_entry;

  // Level handshake: BUF_READY high offers a frozen record and must stay high until
  // VGA_WRITE_DONE is seen; dropping it earlier abandons the copy.
  assign read_entry = (state == WAIT_VB) && BUF_READY && VBLANK;
  assign done_entry = (state == FLUSH) && BUF_READY && flush_cnt;
  assign STATE_DBG  = state;

  always_ff @(posedge CLK_64MHZ or negedge MASTER_RST_N) begin
    if (!MASTER_RST_N) begin
      state          <= IDLE;
      start_addr     <= 11'd0;
      rd_idx         <= 10'd0;
      pipe_idx       <= 10'd0;
      pipe_vld       <= 1'b0;
      flush_cnt      <= 1'b0;
      RAM_ADDR       <= 11'd0;
      TRACE_ADDR     <= 10'd0;
      TRACE_DATA     <= 8'd0;
      TRACE_WE       <= 1'b0;
      VGA_WRITE_DONE <= 1'b0;
    end else begin
      // Second pipeline stage: RAM_DATA now belongs to the address issued last cycle.
      pipe_vld <= 1'b0;
      if (pipe_vld) begin
        TRACE_WE   <= 1'b1;
        TRACE_ADDR <= pipe_idx;
        TRACE_DATA <= RAM_DATA;
      end else begin
        TRACE_WE <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (BUF_READY) begin
            start_addr <= TRIG_ADDR - PRE_TRIG_W;
            state      <= WAIT_VB;
          end
        end
        WAIT_VB: begin
          if (read_entry) begin
            state    <= READ;
            RAM_ADDR <= start_addr;
            rd_idx   <= 10'd0;
          end else if (!BUF_READY) begin
            state <= IDLE;
          end
        end
        READ: begin
          if (!BUF_READY) begin
            state    <= IDLE;
            TRACE_WE <= 1'b0;
          end else begin
            pipe_vld <= 1'b1;
            pipe_idx <= rd_idx;
            if (rd_idx == LAST_IDX) begin
              state     <= FLUSH;
              flush_cnt <= 1'b0;
            end else begin
              rd_idx   <= rd_idx + 10'd1;
              RAM_ADDR <= RAM_ADDR + 11'd1;
            end
          end
        end
        FLUSH: begin
          if (done_entry) begin
            state          <= DONE;
            VGA_WRITE_DONE <= 1'b1;
          end else if (!BUF_READY) begin
            state    <= IDLE;
            TRACE_WE <= 1'b0;
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        DONE: begin
          if (!BUF_READY) begin
            state          <= IDLE;
            VGA_WRITE_DONE <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TRACE_PEAK_DETECT_EN
  logic [7:0] run_min;
  logic [7:0] run_max;

  // Running extremes follow the samples entering the write stage; published only on DONE entry.
  always_ff @(posedge CLK_64MHZ or negedge MASTER_RST_N) begin
    if (!MASTER_RST_N) begin
      run_min   <= 8'hFF;
      run_max   <= 8'h00;
      TRACE_MIN <= 8'h00;
      TRACE_MAX <= 8'h00;
    end else begin
      if (read_entry) begin
        run_min <= 8'hFF;
        run_max <= 8'h00;
      end else if (pipe_vld) begin
        if (RAM_DATA < run_min) run_min <= RAM_DATA;
        if (RAM_DATA > run_max) run_max <= RAM_DATA;
      end
      if (done_entry) begin
        TRACE_MIN <= run_min;
        TRACE_MAX <= run_max;
      end
    end
  end
`else
  assign TRACE_MIN = 8'h00;
  assign TRACE_MAX = 8'h00;
`endif

endmodule
